serial_adder_seq: RTL and testbench

- Parametrised multi-cycle adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock. An internal carry register links consecutive chunks.
- Next generation of the gate-level half/full adder cells: the same arithmetic, but sequential, with a start/done handshake.
- Used as a low-area arithmetic unit for datapath blocks in the combinational/sequential module set.

---
 rtl/serial_adder_pkg.sv | 26 ++
 rtl/serial_adder_seq_chunk_adder.sv | 20 ++
 rtl/serial_adder_seq.sv | 135 +++++++++++++
 tb/tb_serial_adder_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the serial adder.
//   state_t : FSM encoding (IDLE, RUN, DONE)
//   clog2   : counter width helper, never returns less than 1
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to count 0..n-1; a one-chunk adder still gets a 1-bit counter.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_seq_chunk_adder.sv
// chunk_adder: purely combinational W-bit unsigned adder with carry in/out.
// Ports:
//   a, b : W-bit operands
//   cin  : carry in
//   s    : W-bit sum
//   cout : carry out (bit W of a+b+cin)
module chunk_adder #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  // Everything is widened to W+1 bits so the carry lands in the top bit.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: multi-cycle adder computing a + b + cin, CHUNK bits per clock.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request; accepted in IDLE or DONE, ignored while busy
//   a, b  : WIDTH-bit operands, cin : carry in (all captured on accepted start)
//   busy  : high exactly while the FSM is in RUN
//   done  : one-cycle pulse, sum/cout valid
//   sum   : WIDTH-bit result, held until the next completion
//   cout  : final carry, held until the next completion
// Handshake: start is accepted on a rising edge when busy=0 (IDLE or DONE).
// done rises for exactly one cycle NCHUNK edges after acceptance; holding start
// high during DONE launches the next addition back to back.
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = clog2(NCHUNK);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("serial_adder_seq: CHUNK must be >= 1 and divide WIDTH");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  int                 chunk_base;
  logic [CHUNK-1:0]   a_chunk, b_chunk, chunk_s;
  logic               chunk_c;
  logic               take;

  assign chunk_base = int'(cnt_q) * CHUNK;
  assign a_chunk    = a_q[chunk_base +: CHUNK];
  assign b_chunk    = b_q[chunk_base +: CHUNK];

  chunk_adder #(.W(CHUNK)) u_chunk_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_c)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    take     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) take = 1'b1;
      end
      RUN: begin
        shadow_d[chunk_base +: CHUNK] = chunk_s;
        carry_d = chunk_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          // shadow_d already holds the final chunk written just above.
          sum_d   = shadow_d;
          cout_d  = chunk_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (start) take = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Operand capture is shared by IDLE and the back-to-back path out of DONE.
    if (take) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: directed checks of serial_adder_seq with WIDTH=8 at
// CHUNK=1 (instance 0), CHUNK=4 (instance 1) and CHUNK=2 (instance 2).
module tb_serial_adder_seq;

  localparam int WIDTH = 8;
  localparam int CHUNKS [3] = '{1, 4, 2};

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             start_v [3];
  logic             busy_v  [3];
  logic             done_v  [3];
  logic [WIDTH-1:0] sum_v   [3];
  logic             cout_v  [3];

  serial_adder_seq #(.WIDTH(WIDTH), .CHUNK(CHUNKS[0])) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0])
  );
  serial_adder_seq #(.WIDTH(WIDTH), .CHUNK(CHUNKS[1])) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1])
  );
  serial_adder_seq #(.WIDTH(WIDTH), .CHUNK(CHUNKS[2])) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2])
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One complete addition on instance u; checks latency, busy length, result
  // and that done is a single-cycle pulse with the result held afterwards.
  task automatic run_add(input int u, input logic [7:0] x, input logic [7:0] y,
                         input logic c, input logic [7:0] exp_s, input logic exp_c,
                         input string tag);
    int cyc;
    int nbusy;
    int nch;
    nch = WIDTH / CHUNKS[u];
    @(negedge clk);
    a = x; b = y; cin = c; start_v[u] = 1'b1;
    @(negedge clk);
    start_v[u] = 1'b0;
    cyc = 0;
    nbusy = 0;
    while (!done_v[u] && cyc < 64) begin
      if (busy_v[u]) nbusy++;
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_latency"}, cyc, nch);
    check_eq({tag, "_busy_cycles"}, nbusy, nch);
    check_eq({tag, "_busy_in_done"}, {31'b0, busy_v[u]}, 32'd0);
    check_eq({tag, "_sum"}, {24'b0, sum_v[u]}, {24'b0, exp_s});
    check_eq({tag, "_cout"}, {31'b0, cout_v[u]}, {31'b0, exp_c});
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, {31'b0, done_v[u]}, 32'd0);
    check_eq({tag, "_sum_hold"}, {23'b0, cout_v[u], sum_v[u]}, {23'b0, exp_c, exp_s});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, ndone, last, ndone_mid;
    logic [WIDTH:0] e;
    logic [8:0] ref_sum;

    rst = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) begin
      check_eq("reset_busy", {31'b0, busy_v[i]}, 32'd0);
      check_eq("reset_done", {31'b0, done_v[i]}, 32'd0);
      check_eq("reset_sum",  {24'b0, sum_v[i]}, 32'd0);
      check_eq("reset_cout", {31'b0, cout_v[i]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, hand-computed
    run_add(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "c1_ff_01");
    run_add(0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "c1_80_80");
    run_add(1, 8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, "c4_3c_5a_1");
    run_add(2, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "c2_ff_ff_1");
    run_add(2, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "c2_zero");

    // Coarse sweep on CHUNK=4 against a whole-word reference
    for (int x = 0; x < 256; x += 15) begin
      for (int y = 0; y < 256; y += 15) begin
        for (int c = 0; c < 2; c++) begin
          ref_sum = 9'(x) + 9'(y) + 9'(c);
          run_add(1, 8'(x), 8'(y), 1'(c), ref_sum[7:0], ref_sum[8], "c4_sweep");
        end
      end
    end

    // Back-to-back with start held high, CHUNK=2: 10+20 then 200+100
    exp_q.push_back({1'b0, 8'h1E});
    exp_q.push_back({1'b1, 8'h2C});
    @(negedge clk);
    a = 8'd10; b = 8'd20; cin = 1'b0; start_v[2] = 1'b1;
    cyc = 0; ndone = 0; last = 0;
    while (ndone < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done_v[2]) begin
        e = exp_q.pop_front();
        check_eq("b2b_result", {23'b0, cout_v[2], sum_v[2]}, {23'b0, e});
        if (ndone == 1) check_eq("b2b_spacing", cyc - last, 5);
        last = cyc;
        ndone++;
        a = 8'd200; b = 8'd100;
        if (ndone == 2) start_v[2] = 1'b0;
      end
    end
    start_v[2] = 1'b0;
    check_eq("b2b_done_count", ndone, 2);
    @(negedge clk);
    check_eq("b2b_idle_after", {31'b0, busy_v[2] | done_v[2]}, 32'd0);

    // Start re-pulsed and operands changed mid-RUN, CHUNK=1: A5+3C -> E1
    @(negedge clk);
    a = 8'hA5; b = 8'h3C; cin = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    ndone_mid = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_v[0]) begin
        ndone_mid++;
        check_eq("midrun_result", {23'b0, cout_v[0], sum_v[0]}, {23'b0, 1'b0, 8'hE1});
      end
      @(negedge clk);
    end
    check_eq("midrun_done_count", ndone_mid, 1);

    // Asynchronous reset at cycle 3 of RUN, between edges
    @(negedge clk);
    a = 8'h55; b = 8'h22; cin = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("pre_rst_busy", {31'b0, busy_v[0]}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_busy", {31'b0, busy_v[0]}, 32'd0);
    check_eq("async_rst_done", {31'b0, done_v[0]}, 32'd0);
    check_eq("async_rst_sum",  {24'b0, sum_v[0]}, 32'd0);
    check_eq("async_rst_cout", {31'b0, cout_v[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone_mid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) ndone_mid++;
    end
    check_eq("post_rst_quiet", ndone_mid, 0);
    check_eq("post_rst_sum", {23'b0, cout_v[0], sum_v[0]}, 32'd0);
    run_add(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "post_rst_12_34");

    // Idle: 20 cycles without start, result held
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle_busy", {31'b0, busy_v[0]}, 32'd0);
      check_eq("idle_done", {31'b0, done_v[0]}, 32'd0);
      check_eq("idle_sum",  {24'b0, sum_v[0]}, 32'h46);
      check_eq("idle_cout", {31'b0, cout_v[0]}, 32'd0);
    end

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
